// File: rtl/traffic_light_ctrl_timed_if.sv
// Signal bundle between the timed traffic light controller and whatever drives and
// observes it: the two request inputs, the six lamps and the debug/status outputs.
interface traffic_light_ctrl_timed_if;
  // There is no valid/ready handshake: button and night_mode are levels sampled
  // every cycle; a button pulse is remembered in req_pending until it is served.
  logic       button;
  logic       night_mode;
  logic       main_red;
  logic       main_yellow;
  logic       main_green;
  logic       side_red;
  logic       side_yellow;
  logic       side_green;
  logic [2:0] phase;
  logic       req_pending;

  modport master (
    output button, night_mode,
    input  main_red, main_yellow, main_green,
    input  side_red, side_yellow, side_green,
    input  phase, req_pending
  );

  modport slave (
    input  button, night_mode,
    output main_red, main_yellow, main_green,
    output side_red, side_yellow, side_green,
    output phase, req_pending
  );
endinterface

// File: rtl/traffic_light_ctrl_timed.sv
// Main/side-road intersection controller with all-red clearance, per-phase timers,
// an optional automatic side phase and a night flashing mode. Moore outputs only.
module traffic_light_ctrl_timed #(
    parameter int CNT_W       = 8,
    parameter int MIN_GREEN   = 8,
    parameter int SIDE_GREEN  = 5,
    parameter int YELLOW      = 3,
    parameter int ALL_RED     = 1,
    parameter int FLASH_TICKS = 4,
    parameter int AUTO_CYCLE  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    traffic_light_ctrl_timed_if.slave   bus
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        ALL_R1 = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        ALL_R2 = 3'd5,
        FLASH  = 3'd6
    } state_t;

    // Timer reload values: a state of duration D counts D-1 down to 0.
    localparam logic [CNT_W-1:0] LD_MIN_GREEN  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_SIDE_GREEN = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED    = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] LD_FLASH      = CNT_W'(FLASH_TICKS - 1);
    localparam logic             AUTO_EN       = (AUTO_CYCLE != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             req_q, req_d;
    logic             flash_q, flash_d;
    logic             timer_done;

    assign timer_done = (timer_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MAIN_G;
            timer_q <= LD_MIN_GREEN;
            req_q   <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_done ? timer_q : (timer_q - CNT_W'(1));
        flash_d = flash_q;
        case (state_q)
            MAIN_G: begin
                if (timer_done && (bus.night_mode || req_q || AUTO_EN)) begin
                    state_d = MAIN_Y;
                    timer_d = LD_YELLOW;
                end
            end
            MAIN_Y: begin
                if (timer_done) begin
                    state_d = ALL_R1;
                    timer_d = LD_ALL_RED;
                end
            end
            ALL_R1, ALL_R2: begin
                if (timer_done) begin
                    if (bus.night_mode) begin
                        state_d = FLASH;
                        timer_d = LD_FLASH;
                        flash_d = 1'b1;
                    end else if (state_q == ALL_R1) begin
                        state_d = SIDE_G;
                        timer_d = LD_SIDE_GREEN;
                    end else begin
                        state_d = MAIN_G;
                        timer_d = LD_MIN_GREEN;
                    end
                end
            end
            SIDE_G: begin
                if (timer_done) begin
                    state_d = SIDE_Y;
                    timer_d = LD_YELLOW;
                end
            end
            SIDE_Y: begin
                if (timer_done) begin
                    state_d = ALL_R2;
                    timer_d = LD_ALL_RED;
                end
            end
            FLASH: begin
                // Leaving night mode always passes through a full clearance first.
                if (timer_done) begin
                    if (!bus.night_mode) begin
                        state_d = ALL_R2;
                        timer_d = LD_ALL_RED;
                        flash_d = 1'b0;
                    end else begin
                        flash_d = !flash_q;
                        timer_d = LD_FLASH;
                    end
                end
            end
            default: begin
                state_d = MAIN_G;
                timer_d = LD_MIN_GREEN;
                flash_d = 1'b0;
            end
        endcase

        // Clears take priority over a button seen in the same cycle.
        req_d = req_q;
        if (state_d == FLASH && state_q != FLASH) begin
            req_d = 1'b0;
        end else if (state_q == ALL_R1 && state_d == SIDE_G) begin
            req_d = 1'b0;
        end else if (bus.button && state_q != SIDE_G && state_q != FLASH) begin
            req_d = 1'b1;
        end
    end

    always_comb begin
        bus.main_red    = 1'b0;
        bus.main_yellow = 1'b0;
        bus.main_green  = 1'b0;
        bus.side_red    = 1'b0;
        bus.side_yellow = 1'b0;
        bus.side_green  = 1'b0;
        case (state_q)
            MAIN_G: begin
                bus.main_green = 1'b1;
                bus.side_red   = 1'b1;
            end
            MAIN_Y: begin
                bus.main_yellow = 1'b1;
                bus.side_red    = 1'b1;
            end
            SIDE_G: begin
                bus.main_red   = 1'b1;
                bus.side_green = 1'b1;
            end
            SIDE_Y: begin
                bus.main_red    = 1'b1;
                bus.side_yellow = 1'b1;
            end
            FLASH: begin
                bus.main_yellow = flash_q;
                bus.side_red    = flash_q;
            end
            default: begin
                bus.main_red = 1'b1;
                bus.side_red = 1'b1;
            end
        endcase
    end

    assign bus.phase       = state_q;
    assign bus.req_pending = req_q;

endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// Bench for traffic_light_ctrl_timed: per-cycle expected lamp/phase/request words are
// queued from the phase timing tables and compared against the DUT after each edge.
module tb_traffic_light_ctrl_timed;
  localparam logic [2:0] P_MG = 3'd0;
  localparam logic [2:0] P_MY = 3'd1;
  localparam logic [2:0] P_R1 = 3'd2;
  localparam logic [2:0] P_SG = 3'd3;
  localparam logic [2:0] P_SY = 3'd4;
  localparam logic [2:0] P_R2 = 3'd5;
  localparam logic [2:0] P_FL = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel_auto = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  traffic_light_ctrl_timed_if bus_main ();
  traffic_light_ctrl_timed_if bus_auto ();

  traffic_light_ctrl_timed u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_main)
  );

  traffic_light_ctrl_timed #(.AUTO_CYCLE(1)) u_auto (
    .clk (clk),
    .rst (rst),
    .bus (bus_auto)
  );

  // clock / reset
  always #5 clk = ~clk;

  // observation word: {phase, main R/Y/G, side R/Y/G, req_pending}
  function automatic logic [9:0] obs_main();
    return {bus_main.phase, bus_main.main_red, bus_main.main_yellow, bus_main.main_green,
            bus_main.side_red, bus_main.side_yellow, bus_main.side_green, bus_main.req_pending};
  endfunction

  function automatic logic [9:0] obs_auto();
    return {bus_auto.phase, bus_auto.main_red, bus_auto.main_yellow, bus_auto.main_green,
            bus_auto.side_red, bus_auto.side_yellow, bus_auto.side_green, bus_auto.req_pending};
  endfunction

  // expected word from the lamp table
  function automatic logic [9:0] exp_obs(logic [2:0] ph, logic req, logic fl);
    logic [5:0] lamps;
    case (ph)
      P_MG:    lamps = 6'b001_100;
      P_MY:    lamps = 6'b010_100;
      P_SG:    lamps = 6'b100_001;
      P_SY:    lamps = 6'b100_010;
      P_FL:    lamps = {1'b0, fl, 1'b0, fl, 2'b00};
      default: lamps = 6'b100_100;
    endcase
    return {ph, lamps, req};
  endfunction

  task automatic check(string tag, logic [9:0] got, logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %b, expected %b (phase,mR,mY,mG,sR,sY,sG,req) at %0t",
               tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic push(string tag, logic [2:0] ph, logic req, logic fl, int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_obs(ph, req, fl));
      tag_q.push_back(tag);
    end
  endtask

  task automatic drain();
    logic [9:0] e;
    string      t;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, sel_auto ? obs_auto() : obs_main(), e);
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    bus_main.button = 1'b0;
    bus_main.night_mode = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check({tag, "_main"}, obs_main(), exp_obs(P_MG, 1'b0, 1'b0));
    check({tag, "_auto"}, obs_auto(), exp_obs(P_MG, 1'b0, 1'b0));
  endtask

  initial begin
    bus_main.button = 1'b0;
    bus_main.night_mode = 1'b0;
    bus_auto.button = 1'b0;
    bus_auto.night_mode = 1'b0;

    // idle: no request keeps main green
    do_reset("rst_idle");
    push("idle_mg", P_MG, 1'b0, 1'b0, 30);
    drain();

    // single button pulse on cycle 2
    do_reset("rst_pulse");
    push("pulse_mg0", P_MG, 1'b0, 1'b0, 1);
    drain();
    bus_main.button = 1'b1;
    push("pulse_latch", P_MG, 1'b1, 1'b0, 1);
    drain();
    bus_main.button = 1'b0;
    push("pulse_mg", P_MG, 1'b1, 1'b0, 5);
    push("pulse_my", P_MY, 1'b1, 1'b0, 3);
    push("pulse_r1", P_R1, 1'b1, 1'b0, 1);
    push("pulse_sg", P_SG, 1'b0, 1'b0, 5);
    push("pulse_sy", P_SY, 1'b0, 1'b0, 3);
    push("pulse_r2", P_R2, 1'b0, 1'b0, 1);
    push("pulse_back", P_MG, 1'b0, 1'b0, 10);
    drain();

    // button held through a side phase
    do_reset("rst_hold");
    bus_main.button = 1'b1;
    push("hold_mg", P_MG, 1'b1, 1'b0, 7);
    push("hold_my", P_MY, 1'b1, 1'b0, 3);
    push("hold_r1", P_R1, 1'b1, 1'b0, 1);
    push("hold_sg", P_SG, 1'b0, 1'b0, 5);
    push("hold_sy_first", P_SY, 1'b0, 1'b0, 1);
    push("hold_sy_relatch", P_SY, 1'b1, 1'b0, 2);
    push("hold_r2", P_R2, 1'b1, 1'b0, 1);
    drain();
    bus_main.button = 1'b0;
    push("hold_mg2", P_MG, 1'b1, 1'b0, 8);
    push("hold_my2", P_MY, 1'b1, 1'b0, 3);
    drain();

    // automatic cycling, no requests
    do_reset("rst_auto");
    sel_auto = 1'b1;
    push("auto_mg", P_MG, 1'b0, 1'b0, 7);
    for (int k = 0; k < 2; k++) begin
      push("auto_my", P_MY, 1'b0, 1'b0, 3);
      push("auto_r1", P_R1, 1'b0, 1'b0, 1);
      push("auto_sg", P_SG, 1'b0, 1'b0, 5);
      push("auto_sy", P_SY, 1'b0, 1'b0, 3);
      push("auto_r2", P_R2, 1'b0, 1'b0, 1);
      push("auto_mg", P_MG, 1'b0, 1'b0, 8);
    end
    drain();
    sel_auto = 1'b0;

    // night mode requested during side green
    do_reset("rst_night");
    bus_main.button = 1'b1;
    push("night_mg0", P_MG, 1'b1, 1'b0, 1);
    drain();
    bus_main.button = 1'b0;
    push("night_mg", P_MG, 1'b1, 1'b0, 6);
    push("night_my", P_MY, 1'b1, 1'b0, 3);
    push("night_r1", P_R1, 1'b1, 1'b0, 1);
    push("night_sg0", P_SG, 1'b0, 1'b0, 1);
    drain();
    bus_main.night_mode = 1'b1;
    push("night_sg", P_SG, 1'b0, 1'b0, 4);
    push("night_sy0", P_SY, 1'b0, 1'b0, 1);
    drain();
    bus_main.button = 1'b1;
    push("night_sy_latch", P_SY, 1'b1, 1'b0, 1);
    drain();
    bus_main.button = 1'b0;
    push("night_sy", P_SY, 1'b1, 1'b0, 1);
    push("night_r2", P_R2, 1'b1, 1'b0, 1);
    push("flash_entry", P_FL, 1'b0, 1'b1, 1);
    drain();
    bus_main.button = 1'b1;
    push("flash_on", P_FL, 1'b0, 1'b1, 3);
    push("flash_off", P_FL, 1'b0, 1'b0, 4);
    drain();
    bus_main.button = 1'b0;
    push("flash_on2", P_FL, 1'b0, 1'b1, 4);
    drain();
    bus_main.night_mode = 1'b0;
    push("flash_exit_r2", P_R2, 1'b0, 1'b0, 1);
    push("flash_exit_mg", P_MG, 1'b0, 1'b0, 4);
    drain();

    // reset during SIDE_Y with a pending request, then during FLASH
    do_reset("rst_mid");
    bus_main.button = 1'b1;
    push("mid_mg0", P_MG, 1'b1, 1'b0, 1);
    drain();
    bus_main.button = 1'b0;
    push("mid_mg", P_MG, 1'b1, 1'b0, 6);
    push("mid_my", P_MY, 1'b1, 1'b0, 3);
    push("mid_r1", P_R1, 1'b1, 1'b0, 1);
    push("mid_sg", P_SG, 1'b0, 1'b0, 5);
    push("mid_sy", P_SY, 1'b0, 1'b0, 1);
    drain();
    bus_main.button = 1'b1;
    push("mid_sy_latch", P_SY, 1'b1, 1'b0, 1);
    drain();
    do_reset("rst_in_side_y");
    bus_main.night_mode = 1'b1;
    push("nm_mg", P_MG, 1'b0, 1'b0, 7);
    push("nm_my", P_MY, 1'b0, 1'b0, 3);
    push("nm_r1", P_R1, 1'b0, 1'b0, 1);
    push("nm_flash", P_FL, 1'b0, 1'b1, 2);
    drain();
    do_reset("rst_in_flash");
    push("post_rst_mg", P_MG, 1'b0, 1'b0, 3);
    drain();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
